victim_buffer_ctrl: RTL and testbench
=====================================

Name: victim_buffer_ctrl

Overview:
- Small fully-associative victim buffer between L1 data cache and memory.
- Holds lines evicted from L1. Serves L1 miss lookups with an exclusive move-out: a hit invalidates the entry.
- Drives the usage side of the LRU tracker (usage/update_usage) and consumes its one-hot lru output to choose replacement victims.
- Dirty victims leave through a valid/ready writeback port.

Parameters:
- SIZE, 4, number of entries; width of LRU usage/lru vectors.
- TAG_W, 28, line address tag width.
- DATA_W, 256, line data width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- lookup_valid  in  1  lookup request
- lookup_ready  out  1  lookup accepted when valid&&ready
- lookup_tag  in  TAG_W  tag to search
- resp_valid  out  1  lookup response strobe, 1 cycle after accept
- resp_hit  out  1  entry found (and invalidated)
- resp_dirty  out  1  dirty bit of hit entry
- resp_data  out  DATA_W  data of hit entry
- insert_valid  in  1  L1 eviction into buffer
- insert_ready  out  1  insert accepted when valid&&ready
- insert_tag  in  TAG_W
- insert_data  in  DATA_W
- insert_dirty  in  1
- evict_valid  out  1  dirty victim writeback request
- evict_ready  in  1  memory accepts writeback
- evict_tag  out  TAG_W
- evict_data  out  DATA_W
- lru_in  in  SIZE  one-hot least-recently-used slot from LRU tracker
- usage_out  out  SIZE  one-hot slot just written
- update_usage_out  out  1  usage_out takes effect this cycle

Behaviour:
- States: IDLE, EVICT.
- lookup_ready = insert_ready = (state==IDLE).
- Reset (async): state=IDLE; all valid/dirty bits 0; resp_valid, resp_hit, resp_dirty, evict_valid, update_usage_out = 0; resp_data, evict_*, usage_out = 0. Data array need not be reset.
- Lookup (IDLE):
  - Tag compared against valid entries.
  - Next edge: resp_valid=1 for exactly 1 cycle; resp_hit/resp_dirty/resp_data registered.
  - On hit, the entry is invalidated at the same edge.
  - Miss: resp_hit=0, resp_dirty=0, resp_data=0.
  - Tags are unique, so a hit is at most one-hot.
- Same-cycle lookup+insert: all insert decisions use post-lookup valid bits (valid & ~hit_onehot).
  - A slot freed by the lookup is free for the insert.
  - An insert_tag equal to the lookup_tag allocates fresh.
- Insert slot selection (IDLE, accepted), first match wins:
  1. valid entry with equal tag: overwrite data, dirty |= insert_dirty.
  2. lowest-index invalid slot.
  3. slot given by lru_in, if clean: overwritten silently.
  4. slot given by lru_in, if dirty: go to EVICT.
- Cases 1–3 complete at the accept edge. update_usage_out=1 and usage_out=one-hot slot, registered, in the following cycle (1-cycle pulse).
- EVICT:
  - Entry: insert tag/data/dirty and victim index are captured in a holding register. evict_valid=1 with the victim's tag/data, registered from the accept edge.
  - evict_* stay stable while evict_valid && !evict_ready.
  - On the evict handshake: the held insert is written into the victim slot; evict_valid drops next cycle; usage pulse as above; return to IDLE.
  - No lookup or insert is accepted in EVICT.
- lru_in is sampled only at the insert accept edge. An lru_in that is not one-hot is an illegal input; the design takes the lowest set bit.
- usage_out is always one-hot, never all-ones.
- Reset mid-EVICT: pending writeback and held insert are discarded; outputs return to reset values immediately.

Decomposition:
- Package victim_buffer_pkg:
  - state enum vb_state_e {IDLE, EVICT}.
  - entry_t struct {valid, dirty, tag, data}, parameterised via localparams or macros.
- One sub-module, vb_first_one: SIZE-wide lowest-set-bit one-hot encoder with an any-set flag. Used for free-slot selection and lru_in sanitising.

Test Plan (SIZE=4):
- Fill: four clean inserts, tags 0x10..0x13 -> slots 0..3 in order. Usage pulses one cycle later with usage_out 0001, 0010, 0100, 1000. evict_valid never 1.
- Clean replacement: buffer full and clean, lru_in=0100, insert tag 0x20 -> slot 2 overwritten same edge; no eviction; usage_out=0100 next cycle; later lookup 0x12 misses.
- Dirty replacement with backpressure: slot 1 dirty, lru_in=0010, insert 0x30 -> insert_ready=0; evict_valid=1 with tag 0x11. Hold evict_ready=0 for 3 cycles: outputs stable. After the handshake, slot 1 holds 0x30 and state returns to IDLE.
- Lookup hit: lookup 0x13 -> next cycle resp_valid=1, resp_hit=1, data matches; a second lookup of 0x13 misses.
- Same-cycle conflict: full buffer, lru_in=0001 with slot 0 dirty, lookup 0x10 and insert 0x40 in the same cycle -> lookup hits slot 0; insert fills slot 0 with no eviction.
- Merge plus reset: insert 0x11 dirty onto existing clean 0x11 -> same slot, dirty=1. Assert reset mid-EVICT -> evict_valid=0 immediately; all lookups miss afterwards.

Source files
------------

// File: rtl/victim_buffer_pkg.sv
// victim_buffer_pkg: shared sizes, FSM state and entry layout for the victim buffer
package victim_buffer_pkg;
   localparam int SIZE = 4;
   localparam int TAG_W = 28;
   localparam int DATA_W = 256;
   typedef enum logic {IDLE, EVICT} vb_state_e;
   typedef struct packed {
      logic              valid;
      logic              dirty;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } entry_t;
endpackage

// File: rtl/vb_first_one.sv
// vb_first_one: lowest-set-bit one-hot encoder with an any-set flag
module vb_first_one #(parameter int W = 4) (
   input  logic [W-1:0] req_i,
   output logic [W-1:0] onehot_o,
   output logic         any_o
);
   assign onehot_o = req_i & (~req_i + W'(1));
   assign any_o = |req_i;
endmodule

// File: rtl/victim_buffer_ctrl.sv
// victim_buffer_ctrl: fully-associative victim buffer with exclusive lookups and dirty writeback
module victim_buffer_ctrl
   import victim_buffer_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              lookup_valid,
   output logic              lookup_ready,
   input  logic [TAG_W-1:0]  lookup_tag,
   output logic              resp_valid,
   output logic              resp_hit,
   output logic              resp_dirty,
   output logic [DATA_W-1:0] resp_data,
   input  logic              insert_valid,
   output logic              insert_ready,
   input  logic [TAG_W-1:0]  insert_tag,
   input  logic [DATA_W-1:0] insert_data,
   input  logic              insert_dirty,
   output logic              evict_valid,
   input  logic              evict_ready,
   output logic [TAG_W-1:0]  evict_tag,
   output logic [DATA_W-1:0] evict_data,
   input  logic [SIZE-1:0]   lru_in,
   output logic [SIZE-1:0]   usage_out,
   output logic              update_usage_out
);
   vb_state_e         state_q;
   logic [SIZE-1:0]   valid_q, dirty_q, hold_oh_q;
   logic [TAG_W-1:0]  tag_q [SIZE];
   logic [DATA_W-1:0] data_q [SIZE];
   entry_t            hold_q;
   logic              idle, lk_acc, ins_acc, free_any, lru_any, match_any, go_evict;
   logic [SIZE-1:0]   hit_oh, match_oh, post_valid, post_dirty, free_oh, lru_oh, lru_sel, slot_oh, dirty_new;
   logic [TAG_W-1:0]  vic_tag;
   logic [DATA_W-1:0] vic_data, hit_data;

   assign idle = state_q == IDLE;
   assign lookup_ready = idle;
   assign insert_ready = idle;
   assign lk_acc = lookup_valid && idle;
   assign ins_acc = insert_valid && idle;

   // Inserts see the buffer as it stands after this cycle's lookup has moved its hit out
   assign post_valid = valid_q & ~hit_oh;
   assign post_dirty = dirty_q & ~hit_oh;

   vb_first_one #(.W(SIZE)) u_free (.req_i(~post_valid), .onehot_o(free_oh), .any_o(free_any));
   vb_first_one #(.W(SIZE)) u_lru (.req_i(lru_in), .onehot_o(lru_oh), .any_o(lru_any));

   // An all-zero lru_in is meaningless; fall back to slot 0 so the victim is always one-hot
   assign lru_sel = lru_any ? lru_oh : SIZE'(1);
   assign match_any = |match_oh;
   assign slot_oh = match_any ? match_oh : free_any ? free_oh : lru_sel;
   assign go_evict = ins_acc && !match_any && !free_any && |(lru_sel & dirty_q);
   assign dirty_new = (match_any ? post_dirty : post_dirty & ~slot_oh) | (insert_dirty ? slot_oh : '0);

   // Tag search for lookup and insert, plus mux-out of hit data and victim line
   always_comb begin
      hit_oh = '0;
      match_oh = '0;
      hit_data = '0;
      vic_tag = '0;
      vic_data = '0;
      for (int i = 0; i < SIZE; i++) begin
         hit_oh[i] = lk_acc && valid_q[i] && tag_q[i] == lookup_tag;
         match_oh[i] = valid_q[i] && !hit_oh[i] && tag_q[i] == insert_tag;
         hit_data = hit_data | (hit_oh[i] ? data_q[i] : '0);
         vic_tag = vic_tag | (lru_sel[i] ? tag_q[i] : '0);
         vic_data = vic_data | (lru_sel[i] ? data_q[i] : '0);
      end
   end

   // Control FSM: valid/dirty bits, lookup response, writeback request and usage pulse
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         valid_q <= '0;
         dirty_q <= '0;
         resp_valid <= 1'b0;
         resp_hit <= 1'b0;
         resp_dirty <= 1'b0;
         resp_data <= '0;
         evict_valid <= 1'b0;
         evict_tag <= '0;
         evict_data <= '0;
         usage_out <= '0;
         update_usage_out <= 1'b0;
      end else begin
         resp_valid <= lk_acc;
         resp_hit <= |hit_oh;
         resp_dirty <= |(hit_oh & dirty_q);
         resp_data <= hit_data;
         update_usage_out <= 1'b0;
         if (idle) begin
            valid_q <= post_valid;
            dirty_q <= post_dirty;
            if (go_evict) begin
               state_q <= EVICT;
               evict_valid <= 1'b1;
               evict_tag <= vic_tag;
               evict_data <= vic_data;
            end else if (ins_acc) begin
               valid_q <= post_valid | slot_oh;
               dirty_q <= dirty_new;
               usage_out <= slot_oh;
               update_usage_out <= 1'b1;
            end
         end else if (evict_ready) begin
            state_q <= IDLE;
            valid_q <= valid_q | hold_oh_q;
            dirty_q <= (dirty_q & ~hold_oh_q) | (hold_q.dirty ? hold_oh_q : '0);
            evict_valid <= 1'b0;
            usage_out <= hold_oh_q;
            update_usage_out <= 1'b1;
         end
      end

   // Line storage and the insert parked while its dirty victim drains; no reset needed
   always_ff @(posedge clk) begin
      if (go_evict) begin
         hold_q <= {1'b1, insert_dirty, insert_tag, insert_data};
         hold_oh_q <= lru_sel;
      end
      for (int i = 0; i < SIZE; i++)
         if (ins_acc && !go_evict && slot_oh[i]) begin
            tag_q[i] <= insert_tag;
            data_q[i] <= insert_data;
         end else if (!idle && evict_ready && hold_oh_q[i]) begin
            tag_q[i] <= hold_q.tag;
            data_q[i] <= hold_q.data;
         end
   end
endmodule

// File: tb/tb_victim_buffer_ctrl.sv
// tb_victim_buffer_ctrl: directed and randomized checks against a per-slot behavioural model
module tb_victim_buffer_ctrl;
   import victim_buffer_pkg::*;
   logic              clk = 1'b0, reset = 1'b1;
   logic              lookup_valid = 1'b0, lookup_ready;
   logic [TAG_W-1:0]  lookup_tag = '0;
   logic              resp_valid, resp_hit, resp_dirty;
   logic [DATA_W-1:0] resp_data;
   logic              insert_valid = 1'b0, insert_ready, insert_dirty = 1'b0;
   logic [TAG_W-1:0]  insert_tag = '0;
   logic [DATA_W-1:0] insert_data = '0;
   logic              evict_valid, evict_ready = 1'b0;
   logic [TAG_W-1:0]  evict_tag;
   logic [DATA_W-1:0] evict_data;
   logic [SIZE-1:0]   lru_in = 4'b0001, usage_out;
   logic              update_usage_out;

   victim_buffer_ctrl dut (
      .clk(clk), .reset(reset),
      .lookup_valid(lookup_valid), .lookup_ready(lookup_ready), .lookup_tag(lookup_tag),
      .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_dirty(resp_dirty), .resp_data(resp_data),
      .insert_valid(insert_valid), .insert_ready(insert_ready), .insert_tag(insert_tag),
      .insert_data(insert_data), .insert_dirty(insert_dirty),
      .evict_valid(evict_valid), .evict_ready(evict_ready), .evict_tag(evict_tag), .evict_data(evict_data),
      .lru_in(lru_in), .usage_out(usage_out), .update_usage_out(update_usage_out)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;

   logic              m_v [SIZE];
   logic              m_d [SIZE];
   logic [TAG_W-1:0]  m_t [SIZE];
   logic [DATA_W-1:0] m_dat [SIZE];
   logic              m_ev, p_dirty;
   int                m_vic;
   logic [TAG_W-1:0]  p_tag;
   logic [DATA_W-1:0] p_data;
   logic              exp_rv, exp_hit, exp_rd, exp_ev, exp_upd;
   logic [DATA_W-1:0] exp_rdata, exp_edata;
   logic [TAG_W-1:0]  exp_etag;
   logic [SIZE-1:0]   exp_usage;

   function automatic logic [DATA_W-1:0] rnd_data();
      logic [DATA_W-1:0] d;
      for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   function automatic logic [SIZE-1:0] bit_of(input int k);
      logic [SIZE-1:0] r;
      r = '0;
      r[k] = 1'b1;
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < SIZE; i++) begin
         m_v[i] = 1'b0;
         m_d[i] = 1'b0;
         m_t[i] = '0;
         m_dat[i] = '0;
      end
      m_ev = 1'b0;
      exp_rv = 1'b0; exp_hit = 1'b0; exp_rd = 1'b0; exp_rdata = '0;
      exp_ev = 1'b0; exp_etag = '0; exp_edata = '0; exp_upd = 1'b0; exp_usage = '0;
   endtask

   // Predict the effect of the coming edge from the current inputs, then advance past it
   task automatic tick();
      int s;
      bit parked;
      exp_rv = 1'b0; exp_hit = 1'b0; exp_rd = 1'b0; exp_rdata = '0; exp_upd = 1'b0;
      parked = 0;
      if (!m_ev) begin
         if (lookup_valid) begin
            exp_rv = 1'b1;
            for (int i = 0; i < SIZE; i++)
               if (m_v[i] && m_t[i] == lookup_tag) begin
                  exp_hit = 1'b1; exp_rd = m_d[i]; exp_rdata = m_dat[i]; m_v[i] = 1'b0;
               end
         end
         if (insert_valid) begin
            s = -1;
            for (int i = 0; i < SIZE; i++) if (s < 0 && m_v[i] && m_t[i] == insert_tag) s = i;
            if (s >= 0) begin
               m_dat[s] = insert_data;
               m_d[s] = m_d[s] | insert_dirty;
            end else begin
               for (int i = 0; i < SIZE; i++) if (s < 0 && !m_v[i]) s = i;
               if (s < 0) begin
                  for (int i = 0; i < SIZE; i++) if (s < 0 && lru_in[i]) s = i;
                  if (s < 0) s = 0;
                  if (m_d[s]) begin
                     parked = 1; m_ev = 1'b1; m_vic = s;
                     p_tag = insert_tag; p_data = insert_data; p_dirty = insert_dirty;
                     exp_ev = 1'b1; exp_etag = m_t[s]; exp_edata = m_dat[s];
                  end
               end
               if (!parked) begin
                  m_v[s] = 1'b1; m_t[s] = insert_tag; m_dat[s] = insert_data; m_d[s] = insert_dirty;
               end
            end
            if (!parked) begin exp_upd = 1'b1; exp_usage = bit_of(s); end
         end
      end else if (evict_ready) begin
         m_v[m_vic] = 1'b1; m_d[m_vic] = p_dirty; m_t[m_vic] = p_tag; m_dat[m_vic] = p_data;
         m_ev = 1'b0; exp_ev = 1'b0; exp_upd = 1'b1; exp_usage = bit_of(m_vic);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      lookup_valid = 1'b0; insert_valid = 1'b0; evict_ready = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
   endtask

   task automatic ins(input logic [TAG_W-1:0] t, input logic d, input logic [SIZE-1:0] l);
      insert_valid = 1'b1; insert_tag = t; insert_dirty = d; insert_data = rnd_data(); lru_in = l;
      tick();
      insert_valid = 1'b0;
   endtask

   task automatic look(input logic [TAG_W-1:0] t);
      lookup_valid = 1'b1; lookup_tag = t;
      tick();
      lookup_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #3;
      total++; if (resp_valid !== 1'b0 || resp_hit !== 1'b0 || resp_dirty !== 1'b0) begin bad++; $display("FAIL reset_resp: got %b%b%b want 000", resp_valid, resp_hit, resp_dirty); end
      total++; if (resp_data !== '0) begin bad++; $display("FAIL reset_resp_data: got %h want 0", resp_data); end
      total++; if (evict_valid !== 1'b0 || evict_tag !== '0 || evict_data !== '0) begin bad++; $display("FAIL reset_evict: valid %b tag %h", evict_valid, evict_tag); end
      total++; if (update_usage_out !== 1'b0 || usage_out !== '0) begin bad++; $display("FAIL reset_usage: got %b/%b want 0/0000", update_usage_out, usage_out); end
      total++; if (lookup_ready !== 1'b1 || insert_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b%b want 11", lookup_ready, insert_ready); end
      do_reset();
   endtask

   task automatic test_fill();
      for (int k = 0; k < SIZE; k++) begin
         ins(TAG_W'(32'h10 + k), 1'b0, 4'b0001);
         total++; if (update_usage_out !== 1'b1 || usage_out !== bit_of(k)) begin bad++; $display("FAIL fill_usage%0d: got %b/%b want 1/%b", k, update_usage_out, usage_out, bit_of(k)); end
         total++; if (evict_valid !== 1'b0) begin bad++; $display("FAIL fill_evict%0d: got %b want 0", k, evict_valid); end
      end
      tick();
      total++; if (update_usage_out !== 1'b0) begin bad++; $display("FAIL fill_pulse: got %b want 0", update_usage_out); end
   endtask

   task automatic test_clean_replace();
      ins(TAG_W'(32'h20), 1'b0, 4'b0100);
      total++; if (evict_valid !== 1'b0 || insert_ready !== 1'b1) begin bad++; $display("FAIL clean_noevict: got ev=%b rdy=%b want 0/1", evict_valid, insert_ready); end
      total++; if (update_usage_out !== 1'b1 || usage_out !== 4'b0100) begin bad++; $display("FAIL clean_usage: got %b/%b want 1/0100", update_usage_out, usage_out); end
      look(TAG_W'(32'h12));
      total++; if (resp_valid !== 1'b1 || resp_hit !== 1'b0 || resp_data !== '0) begin bad++; $display("FAIL clean_miss: got v=%b hit=%b", resp_valid, resp_hit); end
   endtask

   task automatic test_dirty_replace();
      logic [DATA_W-1:0] vd;
      ins(TAG_W'(32'h11), 1'b1, 4'b0001);
      total++; if (usage_out !== 4'b0010 || evict_valid !== 1'b0) begin bad++; $display("FAIL merge_slot: got %b ev=%b want 0010 ev=0", usage_out, evict_valid); end
      evict_ready = 1'b0;
      ins(TAG_W'(32'h30), 1'b0, 4'b0010);
      vd = m_dat[1];
      total++; if (insert_ready !== 1'b0 || lookup_ready !== 1'b0) begin bad++; $display("FAIL evict_ready_low: got %b%b want 00", insert_ready, lookup_ready); end
      total++; if (evict_valid !== 1'b1 || evict_tag !== TAG_W'(32'h11)) begin bad++; $display("FAIL evict_start: got %b tag %h want 1 tag 11", evict_valid, evict_tag); end
      total++; if (update_usage_out !== 1'b0) begin bad++; $display("FAIL evict_nousage: got %b want 0", update_usage_out); end
      for (int k = 0; k < 3; k++) begin
         tick();
         total++; if (evict_valid !== 1'b1 || evict_tag !== TAG_W'(32'h11) || evict_data !== vd) begin bad++; $display("FAIL evict_hold%0d: got %b tag %h", k, evict_valid, evict_tag); end
      end
      evict_ready = 1'b1;
      tick();
      evict_ready = 1'b0;
      total++; if (evict_valid !== 1'b0 || insert_ready !== 1'b1) begin bad++; $display("FAIL evict_done: got ev=%b rdy=%b want 0/1", evict_valid, insert_ready); end
      total++; if (update_usage_out !== 1'b1 || usage_out !== 4'b0010) begin bad++; $display("FAIL evict_usage: got %b/%b want 1/0010", update_usage_out, usage_out); end
      look(TAG_W'(32'h30));
      total++; if (resp_hit !== 1'b1 || resp_dirty !== 1'b0 || resp_data !== exp_rdata) begin bad++; $display("FAIL evict_written: got hit=%b dirty=%b", resp_hit, resp_dirty); end
   endtask

   task automatic test_lookup_hit();
      look(TAG_W'(32'h13));
      total++; if (resp_valid !== 1'b1 || resp_hit !== 1'b1 || resp_data !== exp_rdata) begin bad++; $display("FAIL hit_first: got v=%b hit=%b data %h", resp_valid, resp_hit, resp_data); end
      tick();
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL hit_pulse: got %b want 0", resp_valid); end
      look(TAG_W'(32'h13));
      total++; if (resp_valid !== 1'b1 || resp_hit !== 1'b0 || resp_dirty !== 1'b0) begin bad++; $display("FAIL hit_second: got v=%b hit=%b want 1/0", resp_valid, resp_hit); end
   endtask

   task automatic test_same_cycle();
      do_reset();
      ins(TAG_W'(32'h10), 1'b1, 4'b0001);
      for (int k = 1; k < SIZE; k++) ins(TAG_W'(32'h10 + k), 1'b0, 4'b0001);
      lookup_valid = 1'b1; lookup_tag = TAG_W'(32'h10);
      ins(TAG_W'(32'h40), 1'b0, 4'b0001);
      lookup_valid = 1'b0;
      total++; if (resp_hit !== 1'b1 || resp_dirty !== 1'b1 || resp_data !== exp_rdata) begin bad++; $display("FAIL same_hit: got hit=%b dirty=%b want 1/1", resp_hit, resp_dirty); end
      total++; if (evict_valid !== 1'b0 || usage_out !== 4'b0001 || update_usage_out !== 1'b1) begin bad++; $display("FAIL same_insert: got ev=%b usage %b want 0 0001", evict_valid, usage_out); end
      look(TAG_W'(32'h40));
      total++; if (resp_hit !== 1'b1 || resp_data !== exp_rdata) begin bad++; $display("FAIL same_newline: got hit=%b want 1", resp_hit); end
   endtask

   task automatic test_merge_reset();
      do_reset();
      for (int k = 0; k < SIZE; k++) ins(TAG_W'(32'h10 + k), 1'b0, 4'b0001);
      ins(TAG_W'(32'h11), 1'b1, 4'b0001);
      total++; if (usage_out !== 4'b0010) begin bad++; $display("FAIL mr_merge: got %b want 0010", usage_out); end
      ins(TAG_W'(32'h50), 1'b0, 4'b0010);
      total++; if (evict_valid !== 1'b1 || evict_tag !== TAG_W'(32'h11)) begin bad++; $display("FAIL mr_evict: got %b tag %h want 1 tag 11", evict_valid, evict_tag); end
      #2 reset = 1'b1;
      #1;
      total++; if (evict_valid !== 1'b0 || evict_tag !== '0 || update_usage_out !== 1'b0 || usage_out !== '0) begin bad++; $display("FAIL mr_async: got ev=%b usage %b want 0 0000", evict_valid, usage_out); end
      total++; if (lookup_ready !== 1'b1 || insert_ready !== 1'b1) begin bad++; $display("FAIL mr_ready: got %b%b want 11", lookup_ready, insert_ready); end
      @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
      for (int k = 0; k < SIZE; k++) begin
         look(TAG_W'(32'h10 + k));
         total++; if (resp_valid !== 1'b1 || resp_hit !== 1'b0) begin bad++; $display("FAIL mr_miss%0d: got v=%b hit=%b want 1/0", k, resp_valid, resp_hit); end
      end
      look(TAG_W'(32'h50));
      total++; if (resp_hit !== 1'b0) begin bad++; $display("FAIL mr_miss_held: got %b want 0", resp_hit); end
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 600; n++) begin
         lookup_valid = ($urandom_range(0, 2) == 0);
         lookup_tag = TAG_W'($urandom_range(32'h60, 32'h67));
         insert_valid = ($urandom_range(0, 1) == 0);
         insert_tag = TAG_W'($urandom_range(32'h60, 32'h67));
         insert_dirty = 1'($urandom_range(0, 1));
         insert_data = rnd_data();
         lru_in = SIZE'($urandom_range(1, 15));
         evict_ready = ($urandom_range(0, 2) != 0);
         tick();
         total++; if (resp_valid !== exp_rv || resp_hit !== exp_hit || resp_dirty !== exp_rd) begin bad++; $display("FAIL rnd_resp@%0d: got %b%b%b want %b%b%b", n, resp_valid, resp_hit, resp_dirty, exp_rv, exp_hit, exp_rd); end
         total++; if (resp_data !== exp_rdata) begin bad++; $display("FAIL rnd_data@%0d: got %h want %h", n, resp_data, exp_rdata); end
         total++; if (evict_valid !== exp_ev) begin bad++; $display("FAIL rnd_evict@%0d: got %b want %b", n, evict_valid, exp_ev); end
         if (exp_ev) begin
            total++; if (evict_tag !== exp_etag || evict_data !== exp_edata) begin bad++; $display("FAIL rnd_evict_line@%0d: got tag %h want %h", n, evict_tag, exp_etag); end
         end
         total++; if (update_usage_out !== exp_upd) begin bad++; $display("FAIL rnd_upd@%0d: got %b want %b", n, update_usage_out, exp_upd); end
         if (exp_upd) begin
            total++; if (usage_out !== exp_usage) begin bad++; $display("FAIL rnd_usage@%0d: got %b want %b", n, usage_out, exp_usage); end
         end
         total++; if (lookup_ready !== !m_ev || insert_ready !== !m_ev) begin bad++; $display("FAIL rnd_ready@%0d: got %b%b want %b", n, lookup_ready, insert_ready, !m_ev); end
      end
      lookup_valid = 1'b0; insert_valid = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_fill();
      test_clean_replace();
      test_dirty_replace();
      test_lookup_hit();
      test_same_cycle();
      test_merge_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
